mips_cpu_bus_core: RTL and testbench

- Multicycle MIPS-I subset CPU: fetches and executes instructions over a single Avalon-style memory-mapped bus with waitrequest stalling.
- Sits between the system memory model and the top-level bench.
- Exposes `active` (running/halted) and a live copy of register $2 (v0) for end-of-program checking.
- Halts when execution jumps to address 0x00000000.

---
 rtl/mips_cpu_bus_core.sv | 175 +++++++++++++++++
 tb/tb_mips_cpu_bus_core.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_bus_core.sv
// rtl/mips_cpu_bus_core.sv - multicycle MIPS-I subset CPU on an Avalon-style bus
// FETCH -> EXEC -> (MEM) -> WB; branch targets wait one instruction for the delay slot.
module mips_cpu_bus_core #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        active,
    output logic [31:0] register_v0,
    output logic [31:0] address,
    output logic        write,
    output logic        read,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata
);
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    state_t            state_q;
    logic [31:0]       pc_q, ir_q, npc_q, target_q, res_q, addr_q, wdata_q;
    logic              pending_q, read_q, write_q, wr_en_q;
    logic [4:0]        wr_addr_q;
    logic [31:0][31:0] gpr_q;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, imm_s, imm_z, pc4, ea;
    logic [31:0] alu_d, btarget_d;
    logic [4:0]  wr_addr_d;
    logic        wr_en_d, taken_d, is_lw, is_sw;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign rs_val = gpr_q[rs];
    assign rt_val = gpr_q[rt];
    assign imm_s  = {{16{imm[15]}}, imm};
    assign imm_z  = {16'h0000, imm};
    assign pc4    = pc_q + 32'd4;
    assign ea     = rs_val + imm_s;

    always_comb begin
        alu_d     = 32'h0;
        btarget_d = 32'h0;
        wr_addr_d = rd;
        wr_en_d   = 1'b0;
        taken_d   = 1'b0;
        is_lw     = 1'b0;
        is_sw     = 1'b0;
        case (op)
            6'h00: begin
                wr_en_d = 1'b1;
                case (funct)
                    6'h00: alu_d = rt_val << shamt;
                    6'h02: alu_d = rt_val >> shamt;
                    6'h03: alu_d = $signed(rt_val) >>> shamt;
                    6'h04: alu_d = rt_val << rs_val[4:0];
                    6'h06: alu_d = rt_val >> rs_val[4:0];
                    6'h07: alu_d = $signed(rt_val) >>> rs_val[4:0];
                    6'h08: begin wr_en_d = 1'b0; taken_d = 1'b1; btarget_d = rs_val; end
                    6'h09: begin alu_d = pc_q + 32'd8; taken_d = 1'b1; btarget_d = rs_val; end
                    6'h21: alu_d = rs_val + rt_val;
                    6'h23: alu_d = rs_val - rt_val;
                    6'h24: alu_d = rs_val & rt_val;
                    6'h25: alu_d = rs_val | rt_val;
                    6'h26: alu_d = rs_val ^ rt_val;
                    6'h2A: alu_d = {31'b0, $signed(rs_val) < $signed(rt_val)};
                    6'h2B: alu_d = {31'b0, rs_val < rt_val};
                    default: wr_en_d = 1'b0;
                endcase
            end
            6'h02: begin taken_d = 1'b1; btarget_d = {pc4[31:28], ir_q[25:0], 2'b00}; end
            6'h03: begin
                taken_d = 1'b1; btarget_d = {pc4[31:28], ir_q[25:0], 2'b00};
                wr_en_d = 1'b1; wr_addr_d = 5'd31; alu_d = pc_q + 32'd8;
            end
            6'h04: begin taken_d = (rs_val == rt_val); btarget_d = pc4 + (imm_s << 2); end
            6'h05: begin taken_d = (rs_val != rt_val); btarget_d = pc4 + (imm_s << 2); end
            6'h09: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = rs_val + imm_s; end
            6'h0A: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = {31'b0, $signed(rs_val) < $signed(imm_s)}; end
            6'h0B: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = {31'b0, rs_val < imm_s}; end
            6'h0C: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = rs_val & imm_z; end
            6'h0D: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = rs_val | imm_z; end
            6'h0E: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = rs_val ^ imm_z; end
            6'h0F: begin wr_en_d = 1'b1; wr_addr_d = rt; alu_d = {imm, 16'h0000}; end
            6'h23: begin wr_en_d = 1'b1; wr_addr_d = rt; is_lw = 1'b1; end
            6'h2B: is_sw = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_VECTOR;
            addr_q    <= RESET_VECTOR;
            ir_q      <= 32'h0;
            npc_q     <= 32'h0;
            target_q  <= 32'h0;
            res_q     <= 32'h0;
            wdata_q   <= 32'h0;
            pending_q <= 1'b0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= 5'd0;
            gpr_q     <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (!read_q) begin
                        read_q <= 1'b1;
                    end else if (!waitrequest) begin
                        ir_q    <= readdata;
                        read_q  <= 1'b0;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q     <= alu_d;
                    wr_en_q   <= wr_en_d;
                    wr_addr_q <= wr_addr_d;
                    // Redirect from an earlier branch lands now; this one waits for its delay slot.
                    npc_q     <= pending_q ? target_q : pc4;
                    pending_q <= taken_d;
                    target_q  <= btarget_d;
                    if (is_lw || is_sw) begin
                        addr_q  <= ea;
                        read_q  <= is_lw;
                        write_q <= is_sw;
                        wdata_q <= rt_val;
                        state_q <= S_MEM;
                    end else begin
                        state_q <= S_WB;
                    end
                end
                S_MEM: begin
                    if (!waitrequest) begin
                        if (read_q) res_q <= readdata;
                        read_q  <= 1'b0;
                        write_q <= 1'b0;
                        state_q <= S_WB;
                    end
                end
                S_WB: begin
                    if (wr_en_q && wr_addr_q != 5'd0) gpr_q[wr_addr_q] <= res_q;
                    pc_q   <= npc_q;
                    addr_q <= npc_q;
                    if (npc_q == 32'h0) begin
                        state_q <= S_HALT;
                    end else begin
                        read_q  <= 1'b1;
                        state_q <= S_FETCH;
                    end
                end
                S_HALT: ;
                default: state_q <= S_HALT;
            endcase
        end
    end

    assign active      = (state_q != S_HALT);
    assign register_v0 = gpr_q[2];
    assign address     = addr_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = wdata_q;
    assign byteenable  = 4'b1111;
endmodule

// File: tb/tb_mips_cpu_bus_core.sv
// tb/tb_mips_cpu_bus_core.sv - directed programs for mips_cpu_bus_core with alternating waitrequest
module tb_mips_cpu_bus_core;
    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        active, write, read, waitrequest = 1'b0;
    logic [31:0] register_v0, address, writedata, readdata = 32'h0;
    logic [3:0]  byteenable;

    logic [31:0] mem [logic [31:0]];
    int total = 0, bad = 0;
    int fetches = 0, wr_cnt = 0, bus_err = 0;
    logic [31:0] last_wa = 32'h0, last_wd = 32'h0;
    logic        prev_stall = 1'b0, prev_r = 1'b0, prev_w = 1'b0;
    logic [31:0] prev_a = 32'h0, prev_d = 32'h0;

    mips_cpu_bus_core #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst(rst), .active(active), .register_v0(register_v0),
        .address(address), .write(write), .read(read), .waitrequest(waitrequest),
        .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(negedge clk) begin
        waitrequest = ~waitrequest;
        readdata    = mem_rd(address);
    end

    always @(posedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (write && !waitrequest) begin
                mem[address] = writedata;
                wr_cnt++;
                last_wa = address;
                last_wd = writedata;
            end
            if (read && !waitrequest) fetches++;
            if (read && write) bus_err++;
            if (prev_stall && (address != prev_a || read != prev_r || write != prev_w || writedata != prev_d))
                bus_err++;
            prev_stall = (read || write) && waitrequest;
            prev_a = address; prev_r = read; prev_w = write; prev_d = writedata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic put(input int idx, input logic [31:0] w);
        mem[RV + 32'(idx * 4)] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        fetches = 0;
        wr_cnt  = 0;
        rst = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        int n = 0;
        while (active === 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({"halt_", tag}, {31'b0, active}, 32'h0);
    endtask

    initial begin
        // P1: ADDIU $2,$0,0x7FFF; ADDIU $2,$2,1; JR $0; NOP
        put(0, 32'h24027FFF); put(1, 32'h24420001); put(2, 32'h00000008); put(3, 32'h00000000);
        repeat (3) @(negedge clk);
        chk("rst_read", {31'b0, read}, 32'h0);
        chk("rst_write", {31'b0, write}, 32'h0);
        chk("rst_addr", address, RV);
        chk("rst_wdata", writedata, 32'h0);
        chk("rst_be", {28'b0, byteenable}, 32'hF);
        chk("rst_active", {31'b0, active}, 32'h1);
        chk("rst_v0", register_v0, 32'h0);
        fetches = 0;
        rst = 1'b0;
        @(negedge clk);
        chk("first_read", {31'b0, read}, 32'h1);
        chk("first_addr", address, RV);
        chk("first_active", {31'b0, active}, 32'h1);
        run_to_halt("p1");
        chk("p1_v0", register_v0, 32'h00008000);
        chk("p1_fetches", fetches, 32'd4);
        repeat (4) @(negedge clk);
        chk("p1_halt_read", {30'b0, read, write}, 32'h0);

        // P2: LUI $2,0xFFFF; ORI $2,$2,0x1234; JR $0; NOP
        mem.delete();
        put(0, 32'h3C02FFFF); put(1, 32'h34421234); put(2, 32'h00000008); put(3, 32'h00000000);
        do_reset();
        run_to_halt("p2");
        chk("p2_v0", register_v0, 32'hFFFF1234);

        // P3: build 0xDEADBEEF in $3; SW $3,0x1000($0); LW $2,0x1000($0); JR $0; NOP
        mem.delete();
        put(0, 32'h3C03DEAD); put(1, 32'h3463BEEF); put(2, 32'hAC031000); put(3, 32'h8C021000);
        put(4, 32'h00000008); put(5, 32'h00000000);
        do_reset();
        run_to_halt("p3");
        chk("p3_wr_cnt", wr_cnt, 32'd1);
        chk("p3_wr_addr", last_wa, 32'h00001000);
        chk("p3_wr_data", last_wd, 32'hDEADBEEF);
        chk("p3_v0", register_v0, 32'hDEADBEEF);

        // P4: BEQ $0,$0,+2; ADDIU $2,$2,5 (delay slot); ADDIU $2,$2,100 (skipped); JR $0; NOP
        mem.delete();
        put(0, 32'h10000002); put(1, 32'h24420005); put(2, 32'h24420064); put(3, 32'h00000008);
        put(4, 32'h00000000);
        do_reset();
        run_to_halt("p4");
        chk("p4_v0", register_v0, 32'h5);

        // P6: $4=-1; SRL $2,$4,28; ADDIU $0,$0,5; ADDU $2,$2,$0; JR $0; NOP
        mem.delete();
        put(0, 32'h2404FFFF); put(1, 32'h00041702); put(2, 32'h24000005); put(3, 32'h00401021);
        put(4, 32'h00000008); put(5, 32'h00000000);
        do_reset();
        run_to_halt("p6");
        chk("p6_v0", register_v0, 32'hF);

        // P5: JAL sub; NOP; JR $0; NOP; sub: ADDIU $2,$0,7; JR $31; NOP
        mem.delete();
        put(0, 32'h0FF00004); put(1, 32'h00000000); put(2, 32'h00000008); put(3, 32'h00000000);
        put(4, 32'h24020007); put(5, 32'h03E00008); put(6, 32'h00000000);
        do_reset();
        run_to_halt("p5");
        chk("p5_v0", register_v0, 32'h7);

        do_reset();
        repeat (15) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rw", {30'b0, read, write}, 32'h0);
        chk("midrst_addr", address, RV);
        chk("midrst_active", {31'b0, active}, 32'h1);
        chk("midrst_v0", register_v0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_refetch", {31'b0, read}, 32'h1);
        run_to_halt("p5b");
        chk("p5b_v0", register_v0, 32'h7);

        chk("bus_protocol", bus_err, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
